fft_mc_ctrl: RTL and testbench



---
 rtl/fft_mc_ctrl.sv | 141 ++++++++++++++
 tb/tb_fft_mc_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_mc_ctrl.sv
// Multi-channel FFT core controller: per frame sends one config beat, streams EPOCH_LENGTH
// samples into the core, then tags core output beats with channel and bin index.
module fft_mc_ctrl #(
  parameter int DATA_W       = 32,
  parameter int EPOCH_LENGTH = 256,
  parameter int NUM_CH       = 4,
  parameter int SCALE_W      = 8,
  localparam int BIN_W       = $clog2(EPOCH_LENGTH),
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CFG_W       = 8 * ((SCALE_W + 8) / 8)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                cfg_inv,
  input  logic [SCALE_W-1:0]  cfg_scale,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [CFG_W-1:0]    s_axis_config_tdata,
  output logic                s_axis_config_tvalid,
  input  logic                s_axis_config_tready,
  output logic [2*DATA_W-1:0] s_axis_data_tdata,
  output logic                s_axis_data_tvalid,
  output logic                s_axis_data_tlast,
  input  logic                s_axis_data_tready,
  input  logic [2*DATA_W-1:0] m_axis_data_tdata,
  input  logic                m_axis_data_tvalid,
  input  logic                m_axis_data_tlast,
  output logic [DATA_W-1:0]   o_fft_real,
  output logic [DATA_W-1:0]   o_fft_imag,
  output logic                o_fft_valid,
  output logic                o_fft_done,
  output logic [CH_W-1:0]     o_fft_ch,
  output logic [BIN_W-1:0]    o_fft_bin,
  output logic                o_busy,
  output logic                o_err_tlast
);

  typedef enum logic [1:0] {StIdle, StCfg, StData, StWaitOut} state_t;

  localparam logic [BIN_W-1:0] LastBin = BIN_W'(EPOCH_LENGTH - 1);
  localparam logic [CH_W-1:0]  LastCh  = CH_W'(NUM_CH - 1);

  state_t             r_state;
  logic [CFG_W-1:0]   r_cfg;
  logic [BIN_W-1:0]   r_smp_cnt;
  logic [BIN_W-1:0]   r_bin_cnt;
  logic [CH_W-1:0]    r_ch_cnt;
  logic [DATA_W-1:0]  r_fft_real;
  logic [DATA_W-1:0]  r_fft_imag;
  logic               r_fft_valid;
  logic               r_fft_done;
  logic [CH_W-1:0]    r_fft_ch;
  logic [BIN_W-1:0]   r_fft_bin;
  logic               r_err_tlast;

  logic w_in_data;
  logic w_data_xfer;
  logic w_last_bin;

  assign w_in_data   = (r_state == StData);
  assign w_data_xfer = w_in_data && in_valid && s_axis_data_tready;
  assign w_last_bin  = (r_bin_cnt == LastBin);

  // Sample path is combinational so the core sees zero added latency.
  assign in_ready             = w_in_data && s_axis_data_tready;
  assign s_axis_data_tvalid   = w_in_data && in_valid;
  assign s_axis_data_tlast    = w_in_data && (r_smp_cnt == LastBin);
  assign s_axis_data_tdata    = {{DATA_W{1'b0}}, in_data};
  assign s_axis_config_tvalid = (r_state == StCfg);
  assign s_axis_config_tdata  = r_cfg;

  assign o_fft_real  = r_fft_real;
  assign o_fft_imag  = r_fft_imag;
  assign o_fft_valid = r_fft_valid;
  assign o_fft_done  = r_fft_done;
  assign o_fft_ch    = r_fft_ch;
  assign o_fft_bin   = r_fft_bin;
  assign o_busy      = (r_state != StIdle);
  assign o_err_tlast = r_err_tlast;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_cfg       <= '0;
      r_smp_cnt   <= '0;
      r_bin_cnt   <= '0;
      r_ch_cnt    <= '0;
      r_fft_real  <= '0;
      r_fft_imag  <= '0;
      r_fft_valid <= 1'b0;
      r_fft_done  <= 1'b0;
      r_fft_ch    <= '0;
      r_fft_bin   <= '0;
      r_err_tlast <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (en) begin
            r_state <= StCfg;
            r_cfg   <= CFG_W'({cfg_scale, cfg_inv});
          end
        end
        StCfg: begin
          if (s_axis_config_tready) r_state <= StData;
        end
        StData: begin
          if (w_data_xfer) begin
            if (r_smp_cnt == LastBin) begin
              r_smp_cnt <= '0;
              r_state   <= StWaitOut;
            end else begin
              r_smp_cnt <= r_smp_cnt + 1'b1;
            end
          end
        end
        StWaitOut: begin
          if (m_axis_data_tvalid && w_last_bin) begin
            r_state  <= StIdle;
            r_ch_cnt <= (r_ch_cnt == LastCh) ? '0 : r_ch_cnt + 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase

      // Output beats are tagged in every state; only WAIT_OUT lets them end the frame.
      r_fft_valid <= m_axis_data_tvalid;
      r_fft_done  <= m_axis_data_tvalid && w_last_bin;
      if (m_axis_data_tvalid) begin
        r_fft_real <= m_axis_data_tdata[DATA_W-1:0];
        r_fft_imag <= m_axis_data_tdata[2*DATA_W-1:DATA_W];
        r_fft_bin  <= r_bin_cnt;
        r_fft_ch   <= r_ch_cnt;
        r_bin_cnt  <= w_last_bin ? '0 : r_bin_cnt + 1'b1;
        if (m_axis_data_tlast != w_last_bin) r_err_tlast <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fft_mc_ctrl.sv
// Bench for fft_mc_ctrl: table of frame configurations plus random stalls, checked against a
// transaction-level model of sample ordering, bin tagging and channel rotation.
module tb_fft_mc_ctrl;
  localparam int DATA_W = 32;
  localparam int EPOCH  = 256;

  logic        clk = 1'b0;
  logic        rst, en, cfg_inv;
  logic [7:0]  cfg_scale;
  logic [31:0] in_data;
  logic        in_valid, in_ready;
  logic [15:0] cfg_tdata;
  logic        cfg_tvalid, cfg_tready;
  logic [63:0] d_tdata;
  logic        d_tvalid, d_tlast, d_tready;
  logic [63:0] m_tdata;
  logic        m_tvalid, m_tlast;
  logic [31:0] o_fft_real, o_fft_imag;
  logic        o_fft_valid, o_fft_done;
  logic [1:0]  o_fft_ch;
  logic [7:0]  o_fft_bin;
  logic        o_busy, o_err_tlast;

  int   checks = 0;
  int   errors = 0;
  logic exp_err = 1'b0;

  typedef struct {
    logic        inv;
    logic [7:0]  scale;
    logic [15:0] exp_cfg;
    logic [1:0]  exp_ch;
  } frame_vec_t;
  frame_vec_t vecs [5];

  always #5 clk = ~clk;

  fft_mc_ctrl dut (
    .clk                  (clk),
    .rst                  (rst),
    .en                   (en),
    .cfg_inv              (cfg_inv),
    .cfg_scale            (cfg_scale),
    .in_data              (in_data),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .s_axis_config_tdata  (cfg_tdata),
    .s_axis_config_tvalid (cfg_tvalid),
    .s_axis_config_tready (cfg_tready),
    .s_axis_data_tdata    (d_tdata),
    .s_axis_data_tvalid   (d_tvalid),
    .s_axis_data_tlast    (d_tlast),
    .s_axis_data_tready   (d_tready),
    .m_axis_data_tdata    (m_tdata),
    .m_axis_data_tvalid   (m_tvalid),
    .m_axis_data_tlast    (m_tlast),
    .o_fft_real           (o_fft_real),
    .o_fft_imag           (o_fft_imag),
    .o_fft_valid          (o_fft_valid),
    .o_fft_done           (o_fft_done),
    .o_fft_ch             (o_fft_ch),
    .o_fft_bin            (o_fft_bin),
    .o_busy               (o_busy),
    .o_err_tlast          (o_err_tlast)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; drives activity on every input so reset priority is exercised.
  task automatic apply_reset();
    rst = 1'b1; en = 1'b0; in_valid = 1'b1; d_tready = 1'b1; cfg_tready = 1'b1;
    m_tvalid = 1'b1; m_tlast = 1'b1; m_tdata = 64'hDEAD_BEEF_1234_5678;
    @(posedge clk); #1;
    check("rst_busy", o_busy, 0);
    check("rst_err", o_err_tlast, 0);
    check("rst_fft_valid", o_fft_valid, 0);
    check("rst_fft_done", o_fft_done, 0);
    check("rst_fft_real", o_fft_real, 0);
    check("rst_fft_imag", o_fft_imag, 0);
    check("rst_fft_ch", o_fft_ch, 0);
    check("rst_fft_bin", o_fft_bin, 0);
    check("rst_cfg_tvalid", cfg_tvalid, 0);
    check("rst_cfg_tdata", cfg_tdata, 0);
    check("rst_d_tvalid", d_tvalid, 0);
    check("rst_d_tlast", d_tlast, 0);
    check("rst_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; d_tready = 1'b0; cfg_tready = 1'b0;
    m_tvalid = 1'b0; m_tlast = 1'b0;
    exp_err = 1'b0;
  endtask

  task automatic run_frame(input logic inv, input logic [7:0] scale, input logic [15:0] exp_cfg,
                           input logic [1:0] exp_ch, input int abort_at, input int err_bin);
    logic [31:0] samples [EPOCH];
    logic [63:0] beat;
    int          idx;
    int          budget;
    int          gap;

    @(negedge clk);
    en = 1'b1; cfg_inv = inv; cfg_scale = scale; cfg_tready = 1'b0;
    @(posedge clk); #1;
    check("cfg_busy", o_busy, 1);
    check("cfg_tvalid", cfg_tvalid, 1);
    check("cfg_tdata", cfg_tdata, exp_cfg);
    // Config must stay put while the core stalls, whatever the cfg inputs do.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      cfg_inv = 1'($urandom); cfg_scale = 8'($urandom);
      @(posedge clk); #1;
      check("cfg_hold_tvalid", cfg_tvalid, 1);
      check("cfg_hold_tdata", cfg_tdata, exp_cfg);
    end
    @(negedge clk);
    cfg_tready = 1'b1;
    @(posedge clk); #1;
    check("cfg_done_tvalid", cfg_tvalid, 0);

    foreach (samples[i]) samples[i] = $urandom;
    idx = 0;
    budget = 0;
    while (idx < EPOCH && budget < 4000) begin
      @(negedge clk);
      budget++;
      cfg_tready = 1'b0;
      en         = (idx < 10);
      cfg_inv    = 1'($urandom);
      cfg_scale  = 8'($urandom);
      if (abort_at >= 0 && idx == abort_at) begin
        apply_reset();
        return;
      end
      in_valid = ($urandom_range(0, 3) != 0);
      d_tready = ($urandom_range(0, 3) != 0);
      in_data  = samples[idx];
      #1;
      check("in_ready", in_ready, d_tready);
      check("d_tvalid", d_tvalid, in_valid);
      if (in_valid && d_tready) begin
        check("d_tdata", d_tdata, {32'b0, samples[idx]});
        check("d_tlast", d_tlast, (idx == EPOCH - 1));
        idx++;
      end
    end
    check("data_all_sent", idx, EPOCH);

    @(negedge clk);
    en = 1'b0; in_valid = 1'b1; d_tready = 1'b1;
    #1;
    check("wait_in_ready", in_ready, 0);
    check("wait_d_tvalid", d_tvalid, 0);
    check("wait_busy", o_busy, 1);

    for (int k = 0; k < EPOCH; k++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(negedge clk);
        in_valid = 1'b0; m_tvalid = 1'b0; m_tlast = 1'($urandom);
        @(posedge clk); #1;
        check("gap_valid", o_fft_valid, 0);
        check("gap_done", o_fft_done, 0);
      end
      @(negedge clk);
      in_valid = 1'b0;
      beat     = {$urandom, $urandom};
      m_tdata  = beat;
      m_tvalid = 1'b1;
      m_tlast  = (err_bin >= 0) ? (k == err_bin) : (k == EPOCH - 1);
      if (m_tlast != (k == EPOCH - 1)) exp_err = 1'b1;
      @(posedge clk); #1;
      check("out_valid", o_fft_valid, 1);
      check("out_bin", o_fft_bin, k);
      check("out_done", o_fft_done, (k == EPOCH - 1));
      check("out_real", o_fft_real, beat[31:0]);
      check("out_imag", o_fft_imag, beat[63:32]);
      check("out_ch", o_fft_ch, exp_ch);
      check("out_err", o_err_tlast, exp_err);
      check("out_busy", o_busy, (k != EPOCH - 1));
    end
    @(negedge clk);
    m_tvalid = 1'b0; m_tlast = 1'b0; d_tready = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("idle_busy", o_busy, 0);
      check("idle_cfg_tvalid", cfg_tvalid, 0);
    end
  endtask

  initial begin
    logic [63:0] beat;
    vecs[0] = '{1'b0, 8'hAA, 16'h0154, 2'd0};
    vecs[1] = '{1'b1, 8'h55, 16'h00AB, 2'd1};
    vecs[2] = '{1'b1, 8'hFF, 16'h01FF, 2'd2};
    vecs[3] = '{1'b0, 8'h00, 16'h0000, 2'd3};
    vecs[4] = '{1'b1, 8'h80, 16'h0101, 2'd0};

    rst = 1'b1; en = 1'b0; cfg_inv = 1'b0; cfg_scale = 8'h00; in_data = '0;
    in_valid = 1'b0; cfg_tready = 1'b0; d_tready = 1'b0;
    m_tdata = '0; m_tvalid = 1'b0; m_tlast = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    apply_reset();

    foreach (vecs[i])
      run_frame(vecs[i].inv, vecs[i].scale, vecs[i].exp_cfg, vecs[i].exp_ch, -1, -1);

    // Core tlast on the wrong bin: sticky error, frame still ends on bin count.
    run_frame(1'b0, 8'h3C, 16'h0078, 2'd1, -1, 100);

    // A beat while idle is tagged but leaves the FSM alone.
    @(negedge clk);
    beat = {$urandom, $urandom};
    m_tdata = beat; m_tvalid = 1'b1; m_tlast = 1'b0;
    @(posedge clk); #1;
    check("idle_beat_valid", o_fft_valid, 1);
    check("idle_beat_bin", o_fft_bin, 0);
    check("idle_beat_ch", o_fft_ch, 2);
    check("idle_beat_real", o_fft_real, beat[31:0]);
    check("idle_beat_busy", o_busy, 0);
    check("idle_beat_err", o_err_tlast, 1);
    @(negedge clk);
    m_tvalid = 1'b0;
    @(posedge clk); #1;
    check("idle_beat_after_busy", o_busy, 0);

    @(negedge clk);
    apply_reset();

    // Reset mid-frame, then a full frame must restart at sample 0 on channel 0.
    run_frame(1'b1, 8'h01, 16'h0003, 2'd0, 37, -1);
    @(posedge clk); #1;
    check("post_abort_busy", o_busy, 0);
    run_frame(1'b1, 8'h01, 16'h0003, 2'd0, -1, -1);
    run_frame(1'b0, 8'hAA, 16'h0154, 2'd1, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
